// File: rtl/multiword_add_sequencer.sv
// Multi-word add sequencer: feeds an external combinational 16-bit adder one
// slice per cycle (LSW first), chains the carry, and presents the assembled
// WORDS x 16-bit sum and final carry over a valid/ready output.
module multiword_add_sequencer #(
    parameter int WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*WORDS-1:0]   in_a,
    input  logic [16*WORDS-1:0]   in_b,
    input  logic                  in_cin,
    output logic [15:0]           add_a,
    output logic [15:0]           add_b,
    output logic                  add_cin,
    input  logic [15:0]           add_sum,
    input  logic                  add_cout,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [16*WORDS-1:0]   out_sum,
    output logic                  out_cout
);

    localparam int W     = 16 * WORDS;
    localparam int IDX_W = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WORDS - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_next;
    logic [IDX_W-1:0]   r_idx;
    logic [W-1:0]       r_a;
    logic [W-1:0]       r_b;
    logic [W-1:0]       r_sum;
    logic               r_carry;
    logic               w_last;
    logic               w_accept;
    logic [15:0]        w_a_slice;
    logic [15:0]        w_b_slice;

    assign w_last   = (r_idx == LAST_IDX);
    assign w_accept = (r_state == S_IDLE) && in_valid;

    // Current operand slices, selected purely from registered state so the
    // adder path starts at flops and never sees the raw input ports.
    assign w_a_slice = 16'(r_a >> {r_idx, 4'b0000});
    assign w_b_slice = 16'(r_b >> {r_idx, 4'b0000});

    // Result is always the registered sum/carry; only meaningful while out_valid.
    assign out_sum  = r_sum;
    assign out_cout = r_carry;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic and state-decoded handshake/adder outputs.
    always_comb begin
        w_next    = r_state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        add_a     = 16'h0000;
        add_b     = 16'h0000;
        add_cin   = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                add_a   = w_a_slice;
                add_b   = w_b_slice;
                add_cin = r_carry;
                if (w_last) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // Operand capture, slice index advance, and per-slice sum/carry collection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_idx   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_carry <= 1'b0;
        end else if (w_accept) begin
            r_a     <= in_a;
            r_b     <= in_b;
            r_carry <= in_cin;
            r_idx   <= '0;
        end else if (r_state == S_RUN) begin
            for (int i = 0; i < WORDS; i++) begin
                if (r_idx == IDX_W'(i)) begin
                    r_sum[16*i +: 16] <= add_sum;
                end
            end
            r_carry <= add_cout;
            if (!w_last) begin
                r_idx <= r_idx + 1'b1;
            end
        end
    end

endmodule
